// File: rtl/div_pipe.sv
// div_pipe: pipelined unsigned restoring divider.
// N (WN bits) / D (WD bits) -> Q (WN bits), R (WD bits), one quotient bit
// per stage, MSB first. A new operation may enter every clock.
//
// Handshake: in_valid marks N/D as an operation on the cycle it is sampled;
// out_valid marks Q/R/dz as a finished result. There is no ready and no
// stall: every sampled cycle, valid or bubble, advances one stage per clock,
// and Q/R/dz carry meaningless bubble contents whenever out_valid is 0.
module div_pipe #(
  parameter int WN = 8,
  parameter int WD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [WN-1:0] N,
  input  logic [WD-1:0] D,
  output logic          out_valid,
  output logic [WN-1:0] Q,
  output logic [WD-1:0] R,
  output logic          dz
);

  // Per-stage registers, index 0 is the input register stage. The partial
  // remainder is always < D, so its MSB is never stored.
  logic [WN-1:0] v_q;
  logic [WN-1:0] dz_q;
  logic [WN-1:0] n_q   [0:WN-1];
  logic [WD-1:0] d_q   [0:WN-1];
  logic [WN-1:0] qt_q  [0:WN-1];
  logic [WD-1:0] rem_q [0:WN-1];

  // Per-stage combinational results; stage i resolves quotient bit WN-i.
  logic [WD:0]   t      [1:WN];
  logic [WN:1]   ge;
  logic [WD-1:0] rem_nx [1:WN];
  logic [WN-1:0] q_nx   [1:WN];

  // Restoring step: shift in the next dividend bit, subtract D if it fits.
  always_comb begin
    for (int i = 1; i <= WN; i++) begin
      t[i]      = {rem_q[i-1], n_q[i-1][WN-i]};
      ge[i]     = (t[i] >= {1'b0, d_q[i-1]});
      // Result is < D whenever a subtraction happens, so WD-bit wrap is exact.
      rem_nx[i] = ge[i] ? (t[i][WD-1:0] - d_q[i-1]) : t[i][WD-1:0];
      q_nx[i]   = qt_q[i-1];
      q_nx[i][WN-i] = ge[i];
    end
  end

  // Pipeline registers and output stage; async reset drops all in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= '0;
      dz_q <= '0;
      for (int i = 0; i < WN; i++) begin
        n_q[i]   <= '0;
        d_q[i]   <= '0;
        qt_q[i]  <= '0;
        rem_q[i] <= '0;
      end
      out_valid <= 1'b0;
      Q         <= '0;
      R         <= '0;
      dz        <= 1'b0;
    end else begin
      // Stage 0: capture the operation; divide-by-zero is decided here.
      v_q[0]   <= in_valid;
      n_q[0]   <= N;
      d_q[0]   <= D;
      dz_q[0]  <= (D == '0);
      qt_q[0]  <= '0;
      rem_q[0] <= '0;
      for (int i = 1; i < WN; i++) begin
        v_q[i]   <= v_q[i-1];
        dz_q[i]  <= dz_q[i-1];
        n_q[i]   <= n_q[i-1];
        d_q[i]   <= d_q[i-1];
        qt_q[i]  <= q_nx[i];
        rem_q[i] <= rem_nx[i];
      end
      // Last stage writes straight into the outputs; D==0 forces Q=all ones, R=0.
      out_valid <= v_q[WN-1];
      dz        <= dz_q[WN-1];
      Q         <= dz_q[WN-1] ? '1 : q_nx[WN];
      R         <= dz_q[WN-1] ? '0 : rem_nx[WN];
    end
  end

endmodule

// File: tb/tb_div_pipe.sv
// tb_div_pipe: directed literal checks plus an exhaustive/random stream,
// all compared against a history-based N/D, N%D model delayed by WN clocks.
module tb_div_pipe;

  localparam int WN  = 8;
  localparam int WD  = 4;
  localparam int LAT = WN;

  typedef struct packed {
    logic          v;
    logic [WN-1:0] n;
    logic [WD-1:0] d;
  } op_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [WN-1:0] n_in = '0;
  logic [WD-1:0] d_in = '0;
  logic          out_valid;
  logic [WN-1:0] q_out;
  logic [WD-1:0] r_out;
  logic          dz_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Operations sampled by the DUT, newest first; cleared by reset.
  op_t hist[$];

  div_pipe #(.WN(WN), .WD(WD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .N         (n_in),
    .D         (d_in),
    .out_valid (out_valid),
    .Q         (q_out),
    .R         (r_out),
    .dz        (dz_out)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Driver tasks: called at a negedge, return at the following negedge.
  task automatic drive(input logic v, input logic [WN-1:0] n, input logic [WD-1:0] d);
    in_valid = v;
    n_in     = n;
    d_in     = d;
    @(negedge clk);
  endtask

  task automatic bubble();
    drive(1'b0, WN'($urandom), WD'($urandom));
  endtask

  // Model: record what the DUT sampled at each edge; reset forgets everything.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist = {};
    end else begin
      op_t o;
      o.v = in_valid;
      o.n = n_in;
      o.d = d_in;
      hist.push_front(o);
      if (hist.size() > LAT + 1) void'(hist.pop_back());
    end
  end

  // Scoreboard: the result on the outputs is the op sampled LAT edges earlier.
  always @(negedge clk) begin
    op_t e;
    int  eq, er, edz;
    e = '0;
    if (hist.size() == LAT + 1) e = hist[LAT];
    chk("sb_valid", int'(out_valid), int'(e.v));
    if (e.v) begin
      if (e.d == 0) begin
        eq = (1 << WN) - 1; er = 0; edz = 1;
      end else begin
        eq = int'(e.n) / int'(e.d);
        er = int'(e.n) % int'(e.d);
        edz = 0;
      end
      chk("sb_q",  int'(q_out),  eq);
      chk("sb_r",  int'(r_out),  er);
      chk("sb_dz", int'(dz_out), edz);
    end
  end

  initial begin
    // Reset state, with in_valid asserted during reset to show it is ignored.
    in_valid = 1'b1;
    n_in = 8'd33;
    d_in = 4'd3;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_q",     int'(q_out),     0);
    chk("rst_r",     int'(r_out),     0);
    chk("rst_dz",    int'(dz_out),    0);
    rst = 1'b0;
    in_valid = 1'b0;

    // Single op 200/7 -> 28 r 4 exactly LAT edges later.
    drive(1'b1, 8'd200, 4'd7);
    repeat (LAT - 1) bubble();
    chk("t1_before", int'(out_valid), 0);
    bubble();
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_q",     int'(q_out),     28);
    chk("t1_r",     int'(r_out),     4);
    chk("t1_dz",    int'(dz_out),    0);
    bubble();
    chk("t1_after", int'(out_valid), 0);
    repeat (10) bubble();

    // Back-to-back ops.
    drive(1'b1, 8'd255, 4'd15);
    drive(1'b1, 8'd100, 4'd13);
    drive(1'b1, 8'd5,   4'd9);
    repeat (LAT - 3) bubble();
    bubble();
    chk("t2_v0", int'(out_valid), 1); chk("t2_q0", int'(q_out), 17); chk("t2_r0", int'(r_out), 0);
    bubble();
    chk("t2_v1", int'(out_valid), 1); chk("t2_q1", int'(q_out), 7);  chk("t2_r1", int'(r_out), 9);
    bubble();
    chk("t2_v2", int'(out_valid), 1); chk("t2_q2", int'(q_out), 0);  chk("t2_r2", int'(r_out), 5);
    repeat (10) bubble();

    // Divide by zero followed by a divide by one.
    drive(1'b1, 8'd77, 4'd0);
    drive(1'b1, 8'd77, 4'd1);
    repeat (LAT - 2) bubble();
    bubble();
    chk("t3_valid", int'(out_valid), 1);
    chk("t3_dz",    int'(dz_out),    1);
    chk("t3_q",     int'(q_out),     255);
    chk("t3_r",     int'(r_out),     0);
    bubble();
    chk("t3b_valid", int'(out_valid), 1);
    chk("t3b_dz",    int'(dz_out),    0);
    chk("t3b_q",     int'(q_out),     77);
    chk("t3b_r",     int'(r_out),     0);
    repeat (10) bubble();

    // Bubbles between ops: issued at edges 1, 3, 6 -> results at 9, 11, 14.
    drive(1'b1, 8'd50, 4'd5);
    bubble();
    drive(1'b1, 8'd99, 4'd10);
    bubble();
    bubble();
    drive(1'b1, 8'd13, 4'd3);
    for (int k = 7; k <= 15; k++) begin
      bubble();
      chk($sformatf("t4_v%0d", k), int'(out_valid), int'(k == 9 || k == 11 || k == 14));
      if (k == 9)  chk("t4_q9",  int'(q_out), 10);
      if (k == 11) chk("t4_q11", int'(q_out), 9);
      if (k == 14) chk("t4_q14", int'(q_out), 4);
    end
    repeat (10) bubble();

    // Reset mid-flight while results are emerging.
    repeat (LAT + 1) drive(1'b1, WN'($urandom), WD'($urandom_range(1, 15)));
    chk("t5_pre_valid", int'(out_valid), 1);
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", int'(out_valid), 0);
    chk("t5_rst_q",     int'(q_out),     0);
    chk("t5_rst_r",     int'(r_out),     0);
    chk("t5_rst_dz",    int'(dz_out),    0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    drive(1'b1, 8'd108, 4'd12);
    for (int k = 2; k <= 14; k++) begin
      bubble();
      chk($sformatf("t5_v%0d", k), int'(out_valid), int'(k == LAT + 1));
      if (k == LAT + 1) begin
        chk("t5_q", int'(q_out), 9);
        chk("t5_r", int'(r_out), 0);
      end
    end

    // Exhaustive stream, then random valid/bubble mix.
    for (int n = 0; n < (1 << WN); n++)
      for (int d = 0; d < (1 << WD); d++)
        drive(1'b1, WN'(n), WD'(d));
    for (int k = 0; k < 600; k++)
      drive(1'($urandom_range(0, 1)), WN'($urandom), WD'($urandom));
    repeat (LAT + 4) bubble();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
